// File: rtl/mem_arb_pkg.sv
`default_nettype none
//==============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the RAM port arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
package mem_arb_pkg;

    localparam int ID_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam logic [ID_W-1:0] REQ_CPU    = 2'd0;
    localparam logic [ID_W-1:0] REQ_LOADER = 2'd1;
    localparam logic [ID_W-1:0] REQ_VIDEO  = 2'd2;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx, input int n);
        return ((int'(idx) + 1) >= n) ? '0 : idx + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr_pick.sv
`default_nettype none
//==============================================================================
// Module      : mem_arb_rr_pick
// Description : Combinational winner search starting at i_start (mod NUM_REQ).
//               MEM_ARB_FIXED_PRIO_EN: lowest index wins, i_start ignored.
// Revision    : 1.0 - initial release
//==============================================================================
module mem_arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_start,
    output logic [ID_W-1:0]    o_winner,
    output logic               o_any_req
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic w_unused_start;
    assign w_unused_start = ^i_start;
`endif

    always_comb begin
        int idx;
        o_winner  = '0;
        o_any_req = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            idx = i;
`else
            idx = (int'(i_start) + i) % NUM_REQ;
`endif
            if (!o_any_req && i_req[idx]) begin
                o_any_req = 1'b1;
                o_winner  = idx[ID_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one synchronous RAM port between NUM_REQ masters with
//               round-robin grants, a per-grant burst limit and read routing.
//               MEM_ARB_FIXED_PRIO_EN selects fixed priority (master 0 first).
// Revision    : 1.0 - initial release
//==============================================================================
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int RAM_LAT   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [ID_W-1:0]           grant_id
);

    localparam int                 c_CNT_W     = 4;
    localparam logic [c_CNT_W-1:0] c_MAX_BEATS = c_CNT_W'(MAX_BURST);

    arb_state_t          r_state, w_state_nxt;
    logic [ID_W-1:0]     r_owner, w_owner_nxt;
    logic [c_CNT_W-1:0]  r_beat_cnt, w_beat_cnt_nxt;
    logic [ID_W-1:0]     w_pick_start, w_pick;
    logic                w_any_req;
    logic                w_own, w_owner_valid, w_accept, w_last_beat, w_exit, w_rd_push;

    logic [RAM_LAT-1:0]  r_pipe_vld;
    logic [ID_W-1:0]     r_pipe_id [RAM_LAT];
    logic [DATA_W-1:0]   r_rsp_hold;
    logic                w_tail_vld;

    mem_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req     (req_valid),
        .i_start   (w_pick_start),
        .o_winner  (w_pick),
        .o_any_req (w_any_req)
    );

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_pick_start = '0;
`else
    // Next search starts just past the master that most recently released the port.
    logic [ID_W-1:0] r_rr_ptr;
    always_ff @(posedge clk) begin
        if (reset)       r_rr_ptr <= '0;
        else if (w_exit) r_rr_ptr <= wrap_inc(r_owner, NUM_REQ);
    end
    assign w_pick_start = r_rr_ptr;
`endif

    assign w_own         = (r_state == OWN);
    assign w_owner_valid = req_valid[r_owner];
    assign w_accept      = w_own && w_owner_valid && (r_beat_cnt < c_MAX_BEATS);
    assign w_last_beat   = w_accept && (r_beat_cnt == (c_MAX_BEATS - 1'b1));
    assign w_exit        = w_own && (!w_owner_valid || w_last_beat);
    assign w_rd_push     = w_accept && !req_we[r_owner];

    assign req_ready = w_accept ? (NUM_REQ'(1) << r_owner) : '0;
    assign mem_we    = w_accept && req_we[r_owner];
    assign mem_addr  = w_own ? req_addr[r_owner*ADDR_W +: ADDR_W] : '0;
    assign mem_wdata = w_own ? req_wdata[r_owner*DATA_W +: DATA_W] : '0;
    assign grant_id  = r_owner;

    // Every release passes through IDLE, which is the one-cycle re-arbitration bubble.
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt    = OWN;
                    w_owner_nxt    = w_pick;
                    w_beat_cnt_nxt = '0;
                end
            end
            OWN: begin
                if (w_accept) w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                if (w_exit)   w_state_nxt    = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= REQ_CPU;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Read tags travel alongside the RAM latency so responses survive owner changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_vld <= '0;
            for (int k = 0; k < RAM_LAT; k++) r_pipe_id[k] <= '0;
            r_rsp_hold <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_push;
            r_pipe_id[0]  <= r_owner;
            for (int k = 1; k < RAM_LAT; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                r_pipe_id[k]  <= r_pipe_id[k-1];
            end
            if (w_tail_vld) r_rsp_hold <= mem_rdata;
        end
    end

    assign w_tail_vld = r_pipe_vld[RAM_LAT-1];
    assign rsp_valid  = w_tail_vld ? (NUM_REQ'(1) << r_pipe_id[RAM_LAT-1]) : '0;
    assign rsp_rdata  = w_tail_vld ? mem_rdata : r_rsp_hold;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter with a RAM model and a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int NUM_REQ   = 3;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;
    localparam int RAM_LAT   = 1;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0, req_we = '0, req_ready, rsp_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
    logic [DATA_W-1:0]         rsp_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_we;
    logic [ID_W-1:0]           grant_id;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_BURST(MAX_BURST), .RAM_LAT(RAM_LAT)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .grant_id(grant_id)
    );

    function automatic logic [7:0] pat(input int a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
    endfunction

    // RAM: unwritten locations read a fixed address pattern
    bit [7:0]    ram    [65536];
    bit          ram_wr [65536];
    logic [7:0]  ram_pipe [RAM_LAT];
    logic        tb_ld_en = 1'b0;
    logic [15:0] tb_ld_addr = '0;
    logic [7:0]  tb_ld_data = '0;

    always @(posedge clk) begin
        if (tb_ld_en) begin
            ram[tb_ld_addr] <= tb_ld_data; ram_wr[tb_ld_addr] <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata; ram_wr[mem_addr] <= 1'b1;
        end
        ram_pipe[0] <= ram_wr[mem_addr] ? ram[mem_addr] : pat(int'(mem_addr));
        for (int k = 1; k < RAM_LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
    end
    assign mem_rdata = ram_pipe[RAM_LAT-1];

    // Reference model: who owns the port, how many beats, where the search starts
    typedef struct { int id; logic [7:0] data; int due; } rsp_t;
    rsp_t       rsp_q[$];
    logic [7:0] gold [int];
    int         m_own, m_owner, m_beats, m_ptr, cyc;
    logic [NUM_REQ-1:0] exp_ready, exp_rsp_valid;
    logic       exp_we;
    logic [7:0] exp_rdata;
    int         exp_grant;

    function automatic logic [7:0] gold_rd(input int a);
        return gold.exists(a) ? gold[a] : pat(a);
    endfunction

    task automatic model_reset();
        m_own = 0; m_owner = 0; m_beats = 0; m_ptr = 0; cyc = 0;
        rsp_q.delete(); exp_rdata = '0;
    endtask

    task automatic model_cycle();
        int a, c;
        exp_grant = m_owner; exp_ready = '0; exp_we = 1'b0; exp_rsp_valid = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            exp_rsp_valid[rsp_q[0].id] = 1'b1;
            exp_rdata = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end
        if (m_own != 0) begin
            if (req_valid[m_owner]) begin
                a = int'(req_addr[m_owner*ADDR_W +: ADDR_W]);
                exp_ready[m_owner] = 1'b1;
                m_beats++;
                if (req_we[m_owner]) begin
                    exp_we = 1'b1;
                    gold[a] = req_wdata[m_owner*DATA_W +: DATA_W];
                end else begin
                    rsp_q.push_back('{m_owner, gold_rd(a), cyc + RAM_LAT});
                end
            end
            if (!req_valid[m_owner] || m_beats == MAX_BURST) begin
                m_own = 0; m_ptr = (m_owner + 1) % NUM_REQ;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                c = i;
`else
                c = (m_ptr + i) % NUM_REQ;
`endif
                if (m_own == 0 && req_valid[c]) begin
                    m_own = 1; m_owner = c; m_beats = 0;
                end
            end
        end
        cyc++;
    endtask

    task automatic drive_cycle(input logic [2:0] v, input logic [2:0] we,
                               input logic [47:0] a, input logic [23:0] d);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = v; req_we = we; req_addr = a; req_wdata = d;
        @(negedge clk);
        model_cycle();
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1; req_valid = '0; req_we = '0;
        repeat (2) @(posedge clk);
        model_reset();
    endtask

    task automatic preload(input int a, input logic [7:0] d);
        @(posedge clk); #1;
        tb_ld_en = 1'b1; tb_ld_addr = 16'(a); tb_ld_data = d; gold[a] = d;
        @(posedge clk); #1;
        tb_ld_en = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 3'b111; req_we = 3'b000; req_addr = {16'h3, 16'h2, 16'h1};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            tests_run++;
            if (req_ready !== 3'b000 || rsp_valid !== 3'b000 || mem_we !== 1'b0 || grant_id !== 2'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs cyc%0d: ready=%b rsp=%b we=%b gid=%0d, required 000/000/0/0",
                         i, req_ready, rsp_valid, mem_we, grant_id);
            end
        end
        model_reset();
        drive_cycle(3'b111, 3'b000, {16'h3, 16'h2, 16'h1}, '0);
        tests_run++;
        if (req_ready !== 3'b000) begin
            tests_failed++; $display("FAIL reset_first_cycle: ready=%b, required 000", req_ready);
        end
        drive_cycle(3'b111, 3'b000, {16'h3, 16'h2, 16'h1}, '0);
        tests_run++;
        if (req_ready !== 3'b001 || grant_id !== 2'd0) begin
            tests_failed++; $display("FAIL reset_first_grant: ready=%b gid=%0d, required 001/0", req_ready, grant_id);
        end
    endtask

    task automatic test_single_read();
        preload(16'h0010, 8'hA9);
        apply_reset();
        drive_cycle(3'b001, 3'b000, {16'h0, 16'h0, 16'h0010}, '0);
        tests_run++;
        if (req_ready !== 3'b000) begin
            tests_failed++; $display("FAIL single_read_arb: ready=%b, required 000", req_ready);
        end
        drive_cycle(3'b001, 3'b000, {16'h0, 16'h0, 16'h0010}, '0);
        tests_run++;
        if (req_ready !== 3'b001 || mem_addr !== 16'h0010) begin
            tests_failed++; $display("FAIL single_read_accept: ready=%b addr=%h, required 001/0010", req_ready, mem_addr);
        end
        drive_cycle(3'b000, 3'b000, '0, '0);
        tests_run++;
        if (rsp_valid !== 3'b001 || rsp_rdata !== 8'hA9) begin
            tests_failed++; $display("FAIL single_read_rsp: rsp=%b data=%h, required 001/a9", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_fairness();
        logic [2:0] want;
        apply_reset();
        for (int t = 0; t < 20; t++) begin
            drive_cycle(3'b111, 3'b000, {16'h0120, 16'h0110, 16'h0100}, '0);
            want = (t % 5 == 0) ? 3'b000 : 3'(1 << ((t / 5) % 3));
            tests_run++;
            if (req_ready !== want || (t % 5 != 0 && grant_id !== 2'((t / 5) % 3))) begin
                tests_failed++;
                $display("FAIL fairness t=%0d: ready=%b gid=%0d, required %b/%0d", t, req_ready, grant_id, want, (t / 5) % 3);
            end
        end
    endtask

    task automatic test_write_then_read();
        int we_cnt, rsp_cnt;
        we_cnt = 0; rsp_cnt = 0;
        apply_reset();
        for (int t = 0; t < 6; t++) begin
            case (t)
                0, 1:    drive_cycle(3'b010, 3'b010, {16'h0, 16'h0200, 16'h0}, {8'h0, 8'h55, 8'h0});
                2, 3, 4: drive_cycle(3'b001, 3'b000, {16'h0, 16'h0, 16'h0200}, '0);
                default: drive_cycle(3'b000, 3'b000, '0, '0);
            endcase
            if (mem_we) we_cnt++;
            if (rsp_valid != 3'b000) rsp_cnt++;
            if (t == 1) begin
                tests_run++;
                if (mem_we !== 1'b1 || mem_addr !== 16'h0200 || mem_wdata !== 8'h55) begin
                    tests_failed++; $display("FAIL wr_beat: we=%b addr=%h data=%h, required 1/0200/55", mem_we, mem_addr, mem_wdata);
                end
            end
        end
        tests_run++;
        if (rsp_valid !== 3'b001 || rsp_rdata !== 8'h55) begin
            tests_failed++; $display("FAIL rd_after_wr: rsp=%b data=%h, required 001/55", rsp_valid, rsp_rdata);
        end
        tests_run++;
        if (we_cnt != 1 || rsp_cnt != 1) begin
            tests_failed++; $display("FAIL wr_rd_counts: we_pulses=%0d rsps=%0d, required 1/1", we_cnt, rsp_cnt);
        end
    endtask

    task automatic test_early_release();
        logic [2:0] want [10] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
        apply_reset();
        for (int t = 0; t < 10; t++) begin
            drive_cycle((t < 3) ? 3'b101 : 3'b100, 3'b000, {16'h0450, 16'h0, 16'h0400}, '0);
            tests_run++;
            if (req_ready !== want[t] || (t >= 5 && t <= 8 && grant_id !== 2'd2)) begin
                tests_failed++;
                $display("FAIL early_release t=%0d: ready=%b gid=%0d, required %b", t, req_ready, grant_id, want[t]);
            end
        end
    endtask

    task automatic test_reset_inflight();
        apply_reset();
        drive_cycle(3'b001, 3'b000, {16'h0, 16'h0, 16'h0033}, '0);
        drive_cycle(3'b001, 3'b000, {16'h0, 16'h0, 16'h0033}, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
        for (int t = 0; t < 4; t++) begin
            drive_cycle(3'b000, 3'b000, '0, '0);
            tests_run++;
            if (rsp_valid !== 3'b000) begin
                tests_failed++; $display("FAIL reset_inflight t=%0d: rsp=%b, required 000", t, rsp_valid);
            end
        end
    endtask

`ifdef MEM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        apply_reset();
        for (int t = 0; t < 15; t++) begin
            drive_cycle(3'b011, 3'b000, {16'h0, 16'h0510, 16'h0500}, '0);
            tests_run++;
            if (req_ready[1] !== 1'b0) begin
                tests_failed++; $display("FAIL fixed_prio_starve t=%0d: ready=%b, required bit1=0", t, req_ready);
            end
        end
        drive_cycle(3'b010, 3'b000, {16'h0, 16'h0510, 16'h0500}, '0);
        drive_cycle(3'b011, 3'b000, {16'h0, 16'h0510, 16'h0500}, '0);
        tests_run++;
        if (req_ready !== 3'b010 || grant_id !== 2'd1) begin
            tests_failed++; $display("FAIL fixed_prio_bubble: ready=%b gid=%0d, required 010/1", req_ready, grant_id);
        end
    endtask
`endif

    task automatic test_random();
        logic [2:0]  v, we;
        logic [47:0] a;
        logic [23:0] d;
        apply_reset();
        for (int t = 0; t < 400; t++) begin
            v  = 3'($urandom_range(0, 7) | (($urandom_range(0, 3) == 0) ? 0 : 3'b001));
            we = 3'($urandom_range(0, 7));
            a  = {16'h0700 + 16'($urandom_range(0, 7)), 16'h0700 + 16'($urandom_range(0, 7)),
                  16'h0700 + 16'($urandom_range(0, 7))};
            d  = 24'($urandom);
            drive_cycle(v, we, a, d);
            tests_run++;
            if (req_ready !== exp_ready || mem_we !== exp_we || rsp_valid !== exp_rsp_valid ||
                rsp_rdata !== exp_rdata || grant_id !== 2'(exp_grant)) begin
                tests_failed++;
                $display("FAIL random t=%0d: ready=%b we=%b rsp=%b data=%h gid=%0d, required %b/%b/%b/%h/%0d",
                         t, req_ready, mem_we, rsp_valid, rsp_rdata, grant_id,
                         exp_ready, exp_we, exp_rsp_valid, exp_rdata, exp_grant);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_read();
`ifdef MEM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_fairness();
        test_early_release();
`endif
        test_write_then_read();
        test_reset_inflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
